uart_wb_responder: RTL and testbench

Byte-level command responder that terminates the host UART debug protocol inside the SoC and masters the Wishbone bus. It parses the command stream delivered by the UART receiver, performs Wishbone classic writes and reads (e.g. DFII control at 0x9000), and streams read data back through the UART transmitter. It sits between the UART PHY (115200 baud, byte strobes) and the SoC control crossbar.

---
 rtl/uart_wb_responder_if.sv | 37 +++
 rtl/uart_wb_responder.sv | 158 +++++++++++++++
 tb/tb_uart_wb_responder.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_wb_responder_if.sv
// Bundle of the UART byte streams and Wishbone classic master signals
// around uart_wb_responder.
//   rx_data/rx_valid      : byte strobe from the UART receiver (no backpressure)
//   tx_data/tx_valid/ready: response byte stream to the UART transmitter
//   wb_*                  : Wishbone classic bus, word addressed (byte addr [31:2])
//   busy                  : responder is not idle
//   rx_overrun            : one-cycle pulse when a byte arrived that could not be taken
// modport master: the responder side; modport slave: the UART/bus environment side.
interface uart_wb_responder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_ack;
    logic        busy;
    logic        rx_overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack,
        output tx_data, tx_valid, wb_adr, wb_dat_w, wb_sel,
               wb_cyc, wb_stb, wb_we, busy, rx_overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack,
        input  tx_data, tx_valid, wb_adr, wb_dat_w, wb_sel,
               wb_cyc, wb_stb, wb_we, busy, rx_overrun
    );
endinterface

// File: rtl/uart_wb_responder.sv
// Host debug-protocol responder: parses CMD, LEN, ADDR[31:0] (MSB first) frames
// from the UART receiver and issues Wishbone classic word writes (CMD 0x01,
// LEN words follow the address) or reads (CMD 0x02, LEN words are returned
// MSB first through the UART transmitter). The address auto-increments by one
// word after every completed word.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : uart_wb_responder_if.master (UART byte streams + Wishbone master)
// Parameter:
//   RX_TIMEOUT : idle cycles tolerated between bytes of a frame before it is abandoned
module uart_wb_responder #(
    parameter int unsigned RX_TIMEOUT = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_wb_responder_if.master    bus
);
    localparam int unsigned   TW    = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_ADDR,
        S_WDATA,
        S_WB_WR,
        S_WB_RD,
        S_TX
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_cmd_rd;
    logic [7:0]  r_remaining;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_shift;
    logic [1:0]  r_bcnt;
    logic [TW-1:0] r_tcnt;
    logic        r_overrun;

    logic w_is_cmd;
    logic w_receiving;
    logic w_rx_wait;
    logic w_timeout;
    logic w_in_bus;

    assign w_is_cmd    = (bus.rx_data == 8'h01) || (bus.rx_data == 8'h02);
    assign w_rx_wait   = (r_state == S_LEN) || (r_state == S_ADDR) || (r_state == S_WDATA);
    assign w_receiving = (r_state == S_IDLE) || w_rx_wait;
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout   = w_rx_wait && !bus.rx_valid && (r_tcnt == TLAST);
    assign w_in_bus    = (r_state == S_WB_WR) || (r_state == S_WB_RD);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.rx_valid && w_is_cmd) w_state_nxt = S_LEN;
            S_LEN:   if (bus.rx_valid) w_state_nxt = S_ADDR;
            S_ADDR: begin
                if (bus.rx_valid && (r_bcnt == 2'd3)) begin
                    if (r_remaining == 8'd0) w_state_nxt = S_IDLE;
                    else if (r_cmd_rd)       w_state_nxt = S_WB_RD;
                    else                     w_state_nxt = S_WDATA;
                end
            end
            S_WDATA: if (bus.rx_valid && (r_bcnt == 2'd3)) w_state_nxt = S_WB_WR;
            S_WB_WR: begin
                if (bus.wb_ack)
                    w_state_nxt = (r_remaining == 8'd1) ? S_IDLE : S_WDATA;
            end
            S_WB_RD: if (bus.wb_ack) w_state_nxt = S_TX;
            S_TX: begin
                if (bus.tx_ready && (r_bcnt == 2'd3))
                    w_state_nxt = (r_remaining == 8'd1) ? S_IDLE : S_WB_RD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) w_state_nxt = S_IDLE;
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_rd    <= 1'b0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            r_bcnt      <= '0;
            r_tcnt      <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= bus.rx_valid && !w_receiving;

            // Counter is held at zero outside LEN/ADDR/WDATA, so entering LEN starts from zero.
            if (w_rx_wait) r_tcnt <= bus.rx_valid ? '0 : r_tcnt + 1'b1;
            else           r_tcnt <= '0;

            unique case (r_state)
                S_IDLE: begin
                    r_bcnt <= '0;
                    if (bus.rx_valid && w_is_cmd) r_cmd_rd <= (bus.rx_data == 8'h02);
                end
                S_LEN: if (bus.rx_valid) r_remaining <= bus.rx_data;
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        r_bcnt <= r_bcnt + 2'd1;
                        // Only the word address is kept: the last byte contributes bits [7:2].
                        if (r_bcnt == 2'd3) r_addr <= {r_addr[23:0], bus.rx_data[7:2]};
                        else                r_addr <= {r_addr[21:0], bus.rx_data};
                    end
                end
                S_WDATA: begin
                    if (bus.rx_valid) begin
                        r_bcnt  <= r_bcnt + 2'd1;
                        r_wdata <= {r_wdata[23:0], bus.rx_data};
                    end
                end
                S_WB_WR: begin
                    if (bus.wb_ack) begin
                        r_remaining <= r_remaining - 8'd1;
                        r_addr      <= r_addr + 30'd1;
                    end
                end
                S_WB_RD: begin
                    if (bus.wb_ack) begin
                        r_shift <= bus.wb_dat_r;
                        r_addr  <= r_addr + 30'd1;
                    end
                end
                S_TX: begin
                    if (bus.tx_ready) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) r_remaining <= r_remaining - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wb_cyc     = w_in_bus;
    assign bus.wb_stb     = w_in_bus;
    assign bus.wb_we      = (r_state == S_WB_WR);
    assign bus.wb_sel     = w_in_bus ? 4'hF : 4'h0;
    assign bus.wb_adr     = r_addr;
    assign bus.wb_dat_w   = r_wdata;
    assign bus.tx_valid   = (r_state == S_TX);
    assign bus.tx_data    = r_shift[31:24];
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rx_overrun = r_overrun;
endmodule

// File: tb/tb_uart_wb_responder.sv
// Self-checking bench for uart_wb_responder: randomized frames, Wishbone slave
// memory model, randomized transmitter backpressure, and a frame-level
// reference model that derives the expected bus cycles and response bytes.
module tb_uart_wb_responder;
    localparam int unsigned TO = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_wb_responder_if bus();

    uart_wb_responder #(.RX_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [29:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } txn_t;

    int n_checks = 0;
    int n_errors = 0;

    txn_t        got_txn[$];
    txn_t        exp_txn[$];
    logic [7:0]  got_tx[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] slv_mem[logic [29:0]];
    logic [31:0] ref_mem[logic [29:0]];

    bit ack_rand   = 1'b1;
    int ack_delay  = 0;
    int rdy_mode   = 0;
    int ovr_cnt    = 0;
    int cyc_cycles = 0;
    int unstable   = 0;
    int hold_err   = 0;

    // Background contents of unwritten memory words
    function automatic logic [31:0] bg(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Wishbone slave: acks after a delay, keeps a word memory, watches address/data stability
    initial begin
        int wcnt;
        int dly;
        logic [29:0] a0;
        logic [31:0] d0;
        txn_t t;
        bus.wb_ack   = 1'b0;
        bus.wb_dat_r = '0;
        wcnt = 0; dly = 0; a0 = '0; d0 = '0;
        forever begin
            @(negedge clk);
            bus.wb_ack = 1'b0;
            if (bus.wb_cyc) cyc_cycles++;
            if (bus.wb_cyc && bus.wb_stb && !rst) begin
                if (wcnt == 0) begin
                    a0  = bus.wb_adr;
                    d0  = bus.wb_dat_w;
                    dly = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
                end else if (bus.wb_adr !== a0 || (bus.wb_we && bus.wb_dat_w !== d0)) begin
                    unstable++;
                end
                if (wcnt >= dly) begin
                    bus.wb_ack = 1'b1;
                    t.adr = bus.wb_adr; t.we = bus.wb_we; t.dat = bus.wb_dat_w; t.sel = bus.wb_sel;
                    got_txn.push_back(t);
                    if (bus.wb_we) slv_mem[bus.wb_adr] = bus.wb_dat_w;
                    else bus.wb_dat_r = slv_mem.exists(bus.wb_adr) ? slv_mem[bus.wb_adr] : bg(bus.wb_adr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Transmitter side: drives tx_ready, collects accepted bytes, watches hold behaviour
    initial begin
        bit pend;
        logic [7:0] pd;
        int ph;
        bus.tx_ready = 1'b1;
        pend = 1'b0; pd = '0; ph = 0;
        forever begin
            @(negedge clk);
            if (bus.rx_overrun) ovr_cnt++;
            if (pend && !rst && (!bus.tx_valid || bus.tx_data !== pd)) hold_err++;
            ph++;
            case (rdy_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ph[0];
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            pend = 1'b0;
            if (bus.tx_valid) begin
                if (bus.tx_ready) got_tx.push_back(bus.tx_data);
                else begin pend = 1'b1; pd = bus.tx_data; end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = $urandom_range(0, 2);
        repeat (g) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_txn(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (got_txn.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    // Reference model of one frame: word i goes to byte address addr + 4*i (mod 2^32)
    task automatic model_frame(input logic [7:0] cmd, input int len, input logic [31:0] addr,
                               input logic [31:0] wd[$]);
        logic [31:0] ba;
        logic [31:0] w;
        txn_t t;
        for (int i = 0; i < len; i++) begin
            ba = addr + 32'(4 * i);
            t.adr = ba[31:2];
            t.sel = 4'hF;
            if (cmd == 8'h01) begin
                t.we = 1'b1; t.dat = wd[i];
                ref_mem[t.adr] = wd[i];
            end else begin
                t.we = 1'b0; t.dat = '0;
                w = ref_mem.exists(t.adr) ? ref_mem[t.adr] : bg(t.adr);
                exp_tx.push_back(w[31:24]); exp_tx.push_back(w[23:16]);
                exp_tx.push_back(w[15:8]);  exp_tx.push_back(w[7:0]);
            end
            exp_txn.push_back(t);
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int len, input logic [31:0] addr,
                             input logic [31:0] wd[$], output bit ok);
        int base;
        bit wok;
        ok = 1'b1;
        model_frame(cmd, len, addr, wd);
        base = got_txn.size();
        send_byte(cmd); send_byte(8'(len));
        send_byte(addr[31:24]); send_byte(addr[23:16]); send_byte(addr[15:8]); send_byte(addr[7:0]);
        if (cmd == 8'h01) begin
            for (int i = 0; i < len; i++) begin
                send_byte(wd[i][31:24]); send_byte(wd[i][23:16]);
                send_byte(wd[i][15:8]);  send_byte(wd[i][7:0]);
                wait_txn(base + i + 1, wok);
                if (!wok) ok = 1'b0;
            end
        end
        wait_idle(wok);
        if (!wok) ok = 1'b0;
    endtask

    task automatic clear_queues();
        got_txn.delete(); exp_txn.delete(); got_tx.delete(); exp_tx.delete();
    endtask

    task automatic test_reset();
        logic [31:0] v[10];
        string nm[10];
        for (int pass = 0; pass < 2; pass++) begin
            v[0] = 32'(bus.tx_valid);  nm[0] = "tx_valid";
            v[1] = 32'(bus.tx_data);   nm[1] = "tx_data";
            v[2] = 32'(bus.wb_cyc);    nm[2] = "wb_cyc";
            v[3] = 32'(bus.wb_stb);    nm[3] = "wb_stb";
            v[4] = 32'(bus.wb_we);     nm[4] = "wb_we";
            v[5] = 32'(bus.wb_sel);    nm[5] = "wb_sel";
            v[6] = 32'(bus.wb_adr);    nm[6] = "wb_adr";
            v[7] = bus.wb_dat_w;       nm[7] = "wb_dat_w";
            v[8] = 32'(bus.busy);      nm[8] = "busy";
            v[9] = 32'(bus.rx_overrun); nm[9] = "rx_overrun";
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (v[i] !== 32'h0) begin
                    n_errors++;
                    $display("FAIL reset_%s: got %h, expected 0", nm[i], v[i]);
                end
            end
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_writes();
        logic [31:0] wq[$];
        bit ok;
        clear_queues();
        ack_rand = 1'b1;
        wq.delete(); wq.push_back(32'h0000_000E);
        run_frame(8'h01, 1, 32'h0000_9000, wq, ok);
        n_checks++;
        if (!ok || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL write1_done: got ok=%0d busy=%b, expected ok=1 busy=0", ok, bus.busy);
        end
        wq.delete(); wq.push_back(32'h0000_0200); wq.push_back(32'h0000_0002);
        run_frame(8'h01, 2, 32'h0000_900C, wq, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL write2_done: got ok=0, expected ok=1"); end
        n_checks++;
        if (got_txn.size() !== 3) begin
            n_errors++;
            $display("FAIL writes_count: got %0d cycles, expected 3", got_txn.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_txn[i].adr !== exp_txn[i].adr || got_txn[i].we !== 1'b1 ||
                    got_txn[i].dat !== exp_txn[i].dat || got_txn[i].sel !== 4'hF) begin
                    n_errors++;
                    $display("FAIL writes_txn%0d: got adr=%h we=%b dat=%h sel=%h, expected adr=%h we=1 dat=%h sel=f",
                             i, got_txn[i].adr, got_txn[i].we, got_txn[i].dat, got_txn[i].sel,
                             exp_txn[i].adr, exp_txn[i].dat);
                end
            end
            n_checks++;
            if (got_txn[0].adr !== 30'h2400 || got_txn[1].adr !== 30'h2403 || got_txn[2].adr !== 30'h2404) begin
                n_errors++;
                $display("FAIL writes_addr: got %h %h %h, expected 2400 2403 2404",
                         got_txn[0].adr, got_txn[1].adr, got_txn[2].adr);
            end
        end
    endtask

    task automatic test_read_toggle();
        logic [31:0] wq[$];
        logic [7:0] want[4];
        bit ok;
        clear_queues();
        rdy_mode = 1;
        hold_err = 0;
        slv_mem[30'h2400] = 32'h1234_5678;
        ref_mem[30'h2400] = 32'h1234_5678;
        wq.delete();
        run_frame(8'h02, 1, 32'h0000_9000, wq, ok);
        want[0] = 8'h12; want[1] = 8'h34; want[2] = 8'h56; want[3] = 8'h78;
        n_checks++;
        if (!ok || got_tx.size() !== 4 || got_txn.size() !== 1) begin
            n_errors++;
            $display("FAIL read_count: got ok=%0d bytes=%0d cycles=%0d, expected ok=1 bytes=4 cycles=1",
                     ok, got_tx.size(), got_txn.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_tx[i] !== want[i]) begin
                    n_errors++;
                    $display("FAIL read_byte%0d: got %h, expected %h", i, got_tx[i], want[i]);
                end
            end
            n_checks++;
            if (got_txn[0].adr !== 30'h2400 || got_txn[0].we !== 1'b0) begin
                n_errors++;
                $display("FAIL read_txn: got adr=%h we=%b, expected adr=2400 we=0", got_txn[0].adr, got_txn[0].we);
            end
        end
        n_checks++;
        if (hold_err !== 0) begin
            n_errors++;
            $display("FAIL read_hold: got %0d unstable held bytes, expected 0", hold_err);
        end
        rdy_mode = 0;
    endtask

    task automatic test_len_zero();
        logic [31:0] wq[$];
        int c0;
        bit ok1, ok2;
        clear_queues();
        c0 = cyc_cycles;
        wq.delete();
        run_frame(8'h01, 0, 32'h0000_1000, wq, ok1);
        run_frame(8'h02, 0, 32'h0000_2000, wq, ok2);
        n_checks++;
        if (!ok1 || !ok2 || cyc_cycles !== c0 || got_tx.size() !== 0) begin
            n_errors++;
            $display("FAIL len_zero: got ok=%0d%0d cyc_cycles=%0d tx=%0d, expected ok=11 cyc_cycles=%0d tx=0",
                     ok1, ok2, cyc_cycles - c0 + c0, got_tx.size(), c0);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] wq[$];
        int c0;
        bit ok;
        txn_t t;
        clear_queues();
        c0 = cyc_cycles;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        repeat (TO - 5) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL timeout_early: got busy=%b, expected 1", bus.busy); end
        repeat (10) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || cyc_cycles !== c0) begin
            n_errors++;
            $display("FAIL timeout_expire: got busy=%b cyc_cycles=%0d, expected busy=0 cyc_cycles=%0d",
                     bus.busy, cyc_cycles, c0);
        end
        wq.delete(); wq.push_back(32'hCAFE_0001);
        run_frame(8'h01, 1, 32'h0000_3000, wq, ok);
        n_checks++;
        if (!ok || got_txn.size() !== 1 || got_txn[0].adr !== 30'h0C00 || got_txn[0].dat !== 32'hCAFE_0001) begin
            n_errors++;
            $display("FAIL timeout_recover: got ok=%0d cycles=%0d, expected ok=1 one write cafe0001 at 0c00",
                     ok, got_txn.size());
        end
        // Partial second word: first word stays written, no cycle for the fragment
        clear_queues();
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_txn(1, ok);
        send_byte(8'h11); send_byte(8'h22);
        repeat (TO + 5) @(negedge clk);
        t.adr = 30'h1000; t.we = 1'b1; t.dat = 32'hDEAD_BEEF; t.sel = 4'hF;
        ref_mem[t.adr] = t.dat;
        n_checks++;
        if (!ok || bus.busy !== 1'b0 || got_txn.size() !== 1 ||
            got_txn[0].adr !== t.adr || got_txn[0].dat !== t.dat) begin
            n_errors++;
            $display("FAIL timeout_partial: got ok=%0d busy=%b cycles=%0d, expected ok=1 busy=0 one write deadbeef",
                     ok, bus.busy, got_txn.size());
        end
    endtask

    task automatic test_overrun();
        int o0;
        bit ok;
        clear_queues();
        ack_rand = 1'b0; ack_delay = 20;
        o0 = ovr_cnt;
        send_byte(8'h01); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h50); send_byte(8'h04);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        repeat (3) @(negedge clk);
        send_byte(8'hAB);
        wait_txn(1, ok);
        repeat (3) @(negedge clk);
        ref_mem[30'h1401] = 32'hA1B2_C3D4;
        n_checks++;
        if (!ok || ovr_cnt - o0 !== 1) begin
            n_errors++;
            $display("FAIL overrun_pulse: got ok=%0d pulses=%0d, expected ok=1 pulses=1", ok, ovr_cnt - o0);
        end
        n_checks++;
        if (got_txn.size() !== 1 || got_txn[0].adr !== 30'h1401 || got_txn[0].dat !== 32'hA1B2_C3D4 ||
            bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_write: got cycles=%0d busy=%b, expected one write a1b2c3d4 at 1401 busy=0",
                     got_txn.size(), bus.busy);
        end
        o0 = ovr_cnt;
        send_byte(8'h55);
        repeat (3) @(negedge clk);
        n_checks++;
        if (ovr_cnt !== o0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bogus_cmd: got pulses=%0d busy=%b, expected pulses=0 busy=0", ovr_cnt - o0, bus.busy);
        end
        ack_rand = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] wq[$];
        logic [31:0] addr;
        logic [7:0] cmd;
        int len;
        bit ok;
        clear_queues();
        rdy_mode = 2; ack_rand = 1'b1; hold_err = 0; unstable = 0;
        for (int f = 0; f < 14; f++) begin
            cmd = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            len = $urandom_range(0, 4);
            case ($urandom_range(0, 2))
                0:       addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       addr = 32'h0000_1000 | 32'($urandom_range(0, 31));
                default: addr = $urandom;
            endcase
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back($urandom);
            run_frame(cmd, len, addr, wq, ok);
            n_checks++;
            if (!ok) begin n_errors++; $display("FAIL rand_frame%0d: got stalled, expected idle", f); end
        end
        n_checks++;
        if (got_txn.size() !== exp_txn.size()) begin
            n_errors++;
            $display("FAIL rand_cycles: got %0d, expected %0d", got_txn.size(), exp_txn.size());
        end else begin
            foreach (exp_txn[i]) begin
                n_checks++;
                if (got_txn[i].adr !== exp_txn[i].adr || got_txn[i].we !== exp_txn[i].we ||
                    got_txn[i].sel !== 4'hF || (exp_txn[i].we && got_txn[i].dat !== exp_txn[i].dat)) begin
                    n_errors++;
                    $display("FAIL rand_txn%0d: got adr=%h we=%b dat=%h sel=%h, expected adr=%h we=%b dat=%h sel=f",
                             i, got_txn[i].adr, got_txn[i].we, got_txn[i].dat, got_txn[i].sel,
                             exp_txn[i].adr, exp_txn[i].we, exp_txn[i].dat);
                end
            end
        end
        n_checks++;
        if (got_tx.size() !== exp_tx.size()) begin
            n_errors++;
            $display("FAIL rand_tx_count: got %0d, expected %0d", got_tx.size(), exp_tx.size());
        end else begin
            foreach (exp_tx[i]) begin
                n_checks++;
                if (got_tx[i] !== exp_tx[i]) begin
                    n_errors++;
                    $display("FAIL rand_tx%0d: got %h, expected %h", i, got_tx[i], exp_tx[i]);
                end
            end
        end
        n_checks++;
        if (hold_err !== 0 || unstable !== 0) begin
            n_errors++;
            $display("FAIL rand_stability: got hold_err=%0d unstable=%0d, expected 0 0", hold_err, unstable);
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        clear_queues();
        ack_rand = 1'b0; ack_delay = 100000;
        send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h90); send_byte(8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wb_cyc) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL rstmid_cyc: got wb_cyc=0, expected 1"); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.tx_valid, bus.busy, bus.rx_overrun} !== 6'b0 ||
            bus.wb_sel !== 4'h0 || bus.wb_adr !== 30'h0 || bus.wb_dat_w !== 32'h0 || bus.tx_data !== 8'h0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got cyc=%b stb=%b we=%b txv=%b busy=%b adr=%h sel=%h, expected all 0",
                     bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.tx_valid, bus.busy, bus.wb_adr, bus.wb_sel);
        end
        ack_rand = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (got_tx.size() !== 0 || got_txn.size() !== 0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_after: got tx=%0d cycles=%0d busy=%b, expected 0 0 0",
                     got_tx.size(), got_txn.size(), bus.busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_writes();
        test_read_toggle();
        test_len_zero();
        test_timeout();
        test_overrun();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
